// File: rtl/game_controller_if.sv
// Player/board bundle for the doodle-jump game sequencer.
// The board side drives inputs; the controller drives the game outputs.
interface game_controller_if #(
  parameter int SCORE_W = 16
);
  logic               start;
  logic               left;
  logic               right;
  logic [31:0]        doodleY;
  logic [31:0]        minY;
  logic               hasCollide;
  logic               physicsUpdate;
  logic               moveLeft;
  logic               moveRight;
  logic               respawn;
  logic [2:0]         state;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic               gameOver;

  modport master (
    output start, left, right,
    output doodleY, minY, hasCollide,
    input  physicsUpdate, moveLeft, moveRight,
    input  respawn, state, score, lives, gameOver
  );

  modport slave (
    input  start, left, right,
    input  doodleY, minY, hasCollide,
    output physicsUpdate, moveLeft, moveRight,
    output respawn, state, score, lives, gameOver
  );
endinterface

// File: rtl/game_controller.sv
// Game sequencer: physics tick, game FSM, score/lives, move gating.
// All outputs are registered; reset is synchronous active-high.
module game_controller #(
  parameter int TICK_DIV      = 1,
  parameter int LIVES         = 3,
  parameter int GRACE_TICKS   = 8,
  parameter int SCORE_W       = 16,
  parameter int COLLIDE_BONUS = 1
) (
  input logic              clk,
  input logic              reset,
  game_controller_if.slave io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    FALL    = 3'd2,
    RESPAWN = 3'd3,
    OVER    = 3'd4
  } state_t;

  localparam logic [31:0] TDM1   = 32'(TICK_DIV - 1);
  localparam logic [31:0] GRACE  = 32'(GRACE_TICKS);
  localparam logic [3:0]  LIVES0 = 4'(LIVES);
  localparam logic [32:0] SMAX   = (33'd1 << SCORE_W) - 33'd1;
  localparam logic [32:0] BONUS  = 33'(COLLIDE_BONUS);

  state_t             state_q;
  state_t             state_d;
  logic               start_q;
  logic               collide_q;
  logic [31:0]        cnt;
  logic [31:0]        grace;
  logic [31:0]        max_y;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic               phys_r;
  logic               resp_r;
  logic               left_r;
  logic               right_r;
  logic               over_r;

  logic               start_edge;
  logic               in_play;
  logic               tick;
  logic               fall;
  logic               rise;
  logic               gain;
  logic [32:0]        sum;
  logic [SCORE_W-1:0] score_n;

  // Tick, fall and landing detection plus saturating score sum.
  always_comb begin
    start_edge = io.start & ~start_q;
    in_play    = state_q == PLAY;
    tick       = in_play && cnt == TDM1;
    fall       = in_play && grace == '0 && io.doodleY < io.minY;
    rise       = in_play && io.hasCollide && !collide_q;
    gain       = tick && io.doodleY > max_y;
    sum        = 33'(score);
    if (gain)
      sum = sum + {1'b0, io.doodleY - max_y};
    if (rise)
      sum = sum + BONUS;
    score_n = (sum > SMAX) ? SMAX[SCORE_W-1:0]
                           : sum[SCORE_W-1:0];
  end

  // Next-state decode of the game FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = PLAY;
      PLAY:    if (fall) state_d = FALL;
      FALL:    state_d = (lives == 4'd1) ? OVER : RESPAWN;
      RESPAWN: state_d = PLAY;
      OVER:    if (start_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, score/lives and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      collide_q <= 1'b0;
      cnt       <= '0;
      grace     <= '0;
      max_y     <= '0;
      score     <= '0;
      lives     <= '0;
      phys_r    <= 1'b0;
      resp_r    <= 1'b0;
      left_r    <= 1'b0;
      right_r   <= 1'b0;
      over_r    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= io.start;
      collide_q <= io.hasCollide;
      phys_r    <= tick;
      resp_r    <= (state_q == IDLE && start_edge) ||
                   (state_q == FALL && lives != 4'd1);
      left_r    <= in_play && io.left && !io.right;
      right_r   <= in_play && io.right && !io.left;
      over_r    <= state_d == OVER;
      cnt       <= (in_play && !tick) ? cnt + 32'd1 : '0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            score <= '0;
            lives <= LIVES0;
            max_y <= io.doodleY;
            grace <= '0;
          end
        end
        PLAY: begin
          score <= score_n;
          if (gain)
            max_y <= io.doodleY;
          if (tick && grace != '0)
            grace <= grace - 32'd1;
        end
        FALL: lives <= lives - 4'd1;
        RESPAWN: begin
          max_y <= io.doodleY;
          grace <= GRACE;
        end
        default: ;
      endcase
    end
  end

  assign io.state         = state_q;
  assign io.score         = score;
  assign io.lives         = lives;
  assign io.physicsUpdate = phys_r;
  assign io.respawn       = resp_r;
  assign io.moveLeft      = left_r;
  assign io.moveRight     = right_r;
  assign io.gameOver      = over_r;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench: stimulus queues expectations tagged with a cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_controller;

  localparam int F_STATE = 0;
  localparam int F_SCORE = 1;
  localparam int F_LIVES = 2;
  localparam int F_PHYS  = 3;
  localparam int F_RESP  = 4;
  localparam int F_ML    = 5;
  localparam int F_MR    = 6;
  localparam int F_OVER  = 7;

  typedef struct {
    int          cyc;
    int          d;
    int          f;
    logic [31:0] v;
    string       nm;
  } exp_t;

  logic clk;
  logic ra;
  logic rb;
  int   cyc;
  int   ntests;
  int   nfail;
  exp_t q[$];

  game_controller_if #(.SCORE_W(16)) ia();
  game_controller_if #(.SCORE_W(4))  ib();

  game_controller #(
    .TICK_DIV(4), .LIVES(3), .GRACE_TICKS(8),
    .SCORE_W(16), .COLLIDE_BONUS(1)
  ) ua (
    .clk(clk), .reset(ra), .io(ia)
  );

  game_controller #(
    .TICK_DIV(1), .LIVES(3), .GRACE_TICKS(8),
    .SCORE_W(4), .COLLIDE_BONUS(1)
  ) ub (
    .clk(clk), .reset(rb), .io(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic logic [31:0] get(int d, int f);
    logic [31:0] r;
    r = '0;
    if (d == 0) begin
      case (f)
        F_STATE: r = 32'(ia.state);
        F_SCORE: r = 32'(ia.score);
        F_LIVES: r = 32'(ia.lives);
        F_PHYS:  r = 32'(ia.physicsUpdate);
        F_RESP:  r = 32'(ia.respawn);
        F_ML:    r = 32'(ia.moveLeft);
        F_MR:    r = 32'(ia.moveRight);
        default: r = 32'(ia.gameOver);
      endcase
    end else begin
      case (f)
        F_STATE: r = 32'(ib.state);
        F_SCORE: r = 32'(ib.score);
        F_LIVES: r = 32'(ib.lives);
        F_PHYS:  r = 32'(ib.physicsUpdate);
        F_RESP:  r = 32'(ib.respawn);
        F_ML:    r = 32'(ib.moveLeft);
        F_MR:    r = 32'(ib.moveRight);
        default: r = 32'(ib.gameOver);
      endcase
    end
    return r;
  endfunction

  function automatic void push(int k, int d, int f,
                               logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cyc + k;
    e.d   = d;
    e.f   = f;
    e.v   = v;
    e.nm  = nm;
    q.push_back(e);
  endfunction

  // monitor: compare every expectation due in the current cycle
  initial begin
    ntests = 0;
    nfail  = 0;
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= cyc) begin
          logic [31:0] act;
          act = get(q[i].d, q[i].f);
          ntests = ntests + 1;
          if (q[i].cyc < cyc || act !== q[i].v) begin
            nfail = nfail + 1;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     q[i].nm, cyc, act, q[i].v);
          end
          q.delete(i);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ra = 1'b1;
    rb = 1'b1;
    ia.start = 0; ia.left = 0; ia.right = 0;
    ia.doodleY = '0; ia.minY = '0; ia.hasCollide = 0;
    ib.start = 0; ib.left = 0; ib.right = 0;
    ib.doodleY = '0; ib.minY = '0; ib.hasCollide = 0;
    step(2);

    // reset values on A
    push(1, 0, F_STATE, 0, "rst_state");
    push(1, 0, F_SCORE, 0, "rst_score");
    push(1, 0, F_LIVES, 0, "rst_lives");
    push(1, 0, F_PHYS,  0, "rst_phys");
    push(1, 0, F_RESP,  0, "rst_resp");
    push(1, 0, F_OVER,  0, "rst_over");
    step(1);
    ra = 1'b0;

    // start held 5 cycles: one entry, tick every 4th cycle
    ia.doodleY = 32'd100;
    ia.minY    = 32'd50;
    ia.start   = 1;
    push(1, 0, F_STATE, 1, "start_state");
    push(1, 0, F_LIVES, 3, "start_lives");
    push(1, 0, F_SCORE, 0, "start_score");
    push(1, 0, F_RESP,  1, "start_resp");
    for (int k = 2; k <= 6; k++)
      push(k, 0, F_RESP, 0, "resp_once");
    for (int k = 1; k <= 9; k++)
      push(k, 0, F_PHYS, (k == 5 || k == 9) ? 1 : 0, "tick_div4");
    step(5);
    ia.start = 0;

    // movement gating
    ia.left = 1; ia.right = 1;
    push(1, 0, F_ML, 0, "both_ml");
    push(1, 0, F_MR, 0, "both_mr");
    step(1);
    ia.right = 0;
    push(1, 0, F_ML, 1, "left_ml");
    push(1, 0, F_MR, 0, "left_mr");
    step(1);
    ia.left = 0; ia.right = 1;
    push(1, 0, F_ML, 0, "right_ml");
    push(1, 0, F_MR, 1, "right_mr");
    step(1);
    ia.right = 0;
    push(1, 0, F_SCORE, 0, "no_gain");
    step(1);

    // falls with grace, then game over
    ia.doodleY = 32'd5;
    ia.minY    = 32'd9;
    push(1, 0, F_STATE, 2, "fall1");
    push(2, 0, F_STATE, 3, "respawn1");
    push(2, 0, F_RESP,  1, "resp1");
    push(2, 0, F_LIVES, 2, "lives2");
    push(3, 0, F_RESP,  0, "resp1_end");
    for (int k = 3; k <= 35; k++)
      push(k, 0, F_STATE, 1, "grace1");
    push(36, 0, F_STATE, 2, "fall2");
    push(37, 0, F_STATE, 3, "respawn2");
    push(37, 0, F_LIVES, 1, "lives1");
    for (int k = 38; k <= 70; k++)
      push(k, 0, F_STATE, 1, "grace2");
    push(71, 0, F_STATE, 2, "fall3");
    push(72, 0, F_STATE, 4, "over");
    push(72, 0, F_LIVES, 0, "lives0");
    push(72, 0, F_RESP,  0, "over_noresp");
    for (int k = 72; k <= 80; k++) begin
      push(k, 0, F_PHYS, 0, "over_notick");
      push(k, 0, F_OVER, 1, "gameover");
    end
    step(80);

    // restart from OVER
    ia.start = 1;
    push(1, 0, F_STATE, 0, "over_idle");
    push(1, 0, F_LIVES, 0, "over_hold");
    push(1, 0, F_OVER,  0, "over_clr");
    step(1);
    ia.start = 0;
    step(1);
    ia.start = 1;
    push(1, 0, F_STATE, 1, "replay");
    push(1, 0, F_LIVES, 3, "replay_lives");
    push(1, 0, F_SCORE, 0, "replay_score");
    push(2, 0, F_STATE, 2, "replay_fall");
    push(3, 0, F_STATE, 3, "replay_respawn");
    push(3, 0, F_RESP,  1, "replay_resp");
    step(1);
    ia.start = 0;
    step(2);

    // reset while in RESPAWN
    ra = 1'b1;
    push(1, 0, F_STATE, 0, "mid_rst_state");
    push(1, 0, F_LIVES, 0, "mid_rst_lives");
    push(1, 0, F_SCORE, 0, "mid_rst_score");
    push(1, 0, F_RESP,  0, "mid_rst_resp");
    push(1, 0, F_PHYS,  0, "mid_rst_phys");
    push(1, 0, F_OVER,  0, "mid_rst_over");
    push(1, 0, F_ML,    0, "mid_rst_ml");
    step(1);
    ra = 1'b0;
    step(2);

    // score on B: height, landing, saturation at 15
    push(1, 1, F_STATE, 0, "b_rst");
    step(1);
    rb = 1'b0;
    ib.doodleY = 32'd10;
    ib.minY    = 32'd0;
    ib.start   = 1;
    push(1, 1, F_STATE, 1, "b_play");
    push(1, 1, F_SCORE, 0, "b_score0");
    push(1, 1, F_LIVES, 3, "b_lives");
    step(1);
    ib.start   = 0;
    ib.doodleY = 32'd14;
    push(1, 1, F_SCORE, 4, "height4");
    step(1);
    ib.doodleY    = 32'd20;
    ib.hasCollide = 1;
    push(1, 1, F_SCORE, 11, "height_land");
    step(1);
    push(1, 1, F_SCORE, 11, "land_level");
    step(1);
    ib.doodleY = 32'd23;
    push(1, 1, F_SCORE, 14, "score14");
    step(1);
    ib.doodleY = 32'd28;
    push(1, 1, F_SCORE, 15, "sat15");
    step(1);
    ib.doodleY = 32'd40;
    push(1, 1, F_SCORE, 15, "sat_hold");
    step(1);
    ib.hasCollide = 0;
    step(1);
    ib.hasCollide = 1;
    push(1, 1, F_SCORE, 15, "sat_land");
    step(3);

    if (q.size() != 0) begin
      ntests = ntests + q.size();
      nfail  = nfail + q.size();
      $display("FAIL pending got=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
